pc_fetch_unit: RTL and testbench

//  Parametrised fetch-stage program counter for the pipelined core: holds the PC, advances it

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_next_sel.sv | 67 ++++++
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pc_pkg;

    // Fetch FSM: BOOT shows the reset vector as not-yet-valid for one cycle.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // What the pending-redirect buffer does on this edge.
    typedef enum logic [1:0] {
        PEND_KEEP  = 2'd0,
        PEND_CLEAR = 2'd1,
        PEND_LOAD  = 2'd2
    } pend_op_t;

    // Control bundle from the next-pc selector to the register stage.
    typedef struct packed {
        logic     pc_load;
        pend_op_t pend_op;
        logic     misalign;
    } sel_ctl_t;

    localparam int          DEF_XLEN         = 32;
    localparam int          DEF_INSTR_BYTES  = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority mux choosing the next fetch pc and pending-buffer action in RUN.
// Latency: purely combinational; results are registered by pc_fetch_unit.
// Backpressure: stall holds pc and parks a concurrent redirect in the pending buffer.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter int              INSTR_BYTES = DEF_INSTR_BYTES,
    parameter logic [XLEN-1:0] EXC_VECTOR  = XLEN'(DEF_EXC_VECTOR)
) (
    input  logic            exc,
    input  logic            halt,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] pc_plus,
    input  logic            pend_valid,
    input  logic [XLEN-1:0] pend_pc,
    output logic [XLEN-1:0] next_pc,
    output sel_ctl_t        ctl
);

    // INSTR_BYTES is a power of two, so the low bits give the alignment test.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    logic misaligned;

    assign misaligned = (redirect_pc & ALIGN_MASK) != '0;

    // Priority: exc > halt > misaligned redirect > stall > redirect > pending > sequential.
    always_comb begin
        next_pc      = pc_plus;
        ctl.pc_load  = 1'b0;
        ctl.pend_op  = PEND_KEEP;
        ctl.misalign = 1'b0;
        if (exc) begin
            next_pc     = EXC_VECTOR;
            ctl.pc_load = 1'b1;
            ctl.pend_op = PEND_CLEAR;
        end else if (halt) begin
            // Entering HALT: everything holds, halt beats redirect and stall.
            ctl.pc_load = 1'b0;
        end else if (redirect && misaligned) begin
            next_pc      = EXC_VECTOR;
            ctl.pc_load  = 1'b1;
            ctl.pend_op  = PEND_CLEAR;
            ctl.misalign = 1'b1;
        end else if (stall) begin
            // pc holds; a redirect seen now is remembered, newest overwrites.
            if (redirect) begin
                ctl.pend_op = PEND_LOAD;
            end
        end else if (redirect) begin
            next_pc     = redirect_pc;
            ctl.pc_load = 1'b1;
            ctl.pend_op = PEND_CLEAR;
        end else if (pend_valid) begin
            next_pc     = pend_pc;
            ctl.pc_load = 1'b1;
            ctl.pend_op = PEND_CLEAR;
        end else begin
            next_pc     = pc_plus;
            ctl.pc_load = 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with boot/run/halt FSM, redirect, exception vector and pending-redirect buffer.
// Latency: every pc change appears one cycle after the sampling edge; pc_plus is combinational from pc.
// Backpressure: stall freezes pc; a redirect during stall is buffered and applied when stall drops.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter int              INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            exc,
    input  logic            halt,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic            pend_valid
);

    pc_state_t       state_q;
    pc_state_t       state_d;
    logic [XLEN-1:0] pc_q;
    logic            pend_valid_q;
    logic [XLEN-1:0] pend_pc_q;
    logic            misalign_q;
    logic [XLEN-1:0] sel_pc;
    sel_ctl_t        sel_ctl;

    // Wraps silently at the top of the address space.
    assign pc_plus      = pc_q + XLEN'(INSTR_BYTES);
    assign pc           = pc_q;
    assign pc_valid     = (state_q == RUN);
    assign misalign_err = misalign_q;
    assign pend_valid   = pend_valid_q;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES),
        .EXC_VECTOR  (EXC_VECTOR)
    ) u_next_sel (
        .exc         (exc),
        .halt        (halt),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_plus     (pc_plus),
        .pend_valid  (pend_valid_q),
        .pend_pc     (pend_pc_q),
        .next_pc     (sel_pc),
        .ctl         (sel_ctl)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT lasts one cycle; halt parks the unit until an exception.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!exc && halt) state_d = HALT;
            HALT:    if (exc) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // pc, pending-redirect buffer and misalign pulse; only RUN and HALT-exit change them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (sel_ctl.pc_load) begin
                        pc_q <= sel_pc;
                    end
                    case (sel_ctl.pend_op)
                        PEND_CLEAR: pend_valid_q <= 1'b0;
                        PEND_LOAD: begin
                            pend_valid_q <= 1'b1;
                            pend_pc_q    <= redirect_pc;
                        end
                        default: pend_valid_q <= pend_valid_q;
                    endcase
                    misalign_q <= sel_ctl.misalign;
                end
                HALT: begin
                    if (exc) begin
                        pc_q         <= EXC_VECTOR;
                        pend_valid_q <= 1'b0;
                    end
                end
                default: pc_q <= pc_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, exc, halt;
    logic [31:0] redirect_pc;
    logic [31:0] pc, pc_plus;
    logic        pc_valid, misalign_err, pend_valid;

    logic        rst8, stall8, redirect8, exc8, halt8;
    logic [7:0]  redirect_pc8;
    logic [7:0]  pc8, pc_plus8;
    logic        pc_valid8, misalign_err8, pend_valid8;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers, behaviour from the rules).
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
    int          m_st;
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_ppc;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .exc(exc), .halt(halt),
        .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid),
        .misalign_err(misalign_err), .pend_valid(pend_valid)
    );

    pc_fetch_unit #(
        .XLEN(8), .INSTR_BYTES(4), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80)
    ) dut8 (
        .clk(clk), .rst(rst8), .stall(stall8), .redirect(redirect8),
        .redirect_pc(redirect_pc8), .exc(exc8), .halt(halt8),
        .pc(pc8), .pc_plus(pc_plus8), .pc_valid(pc_valid8),
        .misalign_err(misalign_err8), .pend_valid(pend_valid8)
    );

    function automatic void model_step();
        m_mis = 1'b0;
        if (rst) begin
            m_st = M_BOOT; m_pc = 32'h0; m_pv = 1'b0;
        end else if (m_st == M_BOOT) begin
            m_st = M_RUN;
        end else if (m_st == M_HALT) begin
            if (exc) begin
                m_st = M_RUN; m_pc = 32'h80; m_pv = 1'b0;
            end
        end else begin
            if (exc) begin
                m_pc = 32'h80; m_pv = 1'b0;
            end else if (halt) begin
                m_st = M_HALT;
            end else if (redirect && (redirect_pc % 4) != 0) begin
                m_pc = 32'h80; m_mis = 1'b1; m_pv = 1'b0;
            end else if (stall) begin
                if (redirect) begin
                    m_pv = 1'b1; m_ppc = redirect_pc;
                end
            end else if (redirect) begin
                m_pc = redirect_pc; m_pv = 1'b0;
            end else if (m_pv) begin
                m_pc = m_ppc; m_pv = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; redirect = 0; exc = 0; halt = 0; redirect_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        tick(); tick();
        n_checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hold pc=%h valid=%b want pc=0 valid=0", pc, pc_valid); end
        n_checks++; if (pend_valid !== 1'b0 || misalign_err !== 1'b0) begin n_errors++; $display("FAIL reset_flags pend=%b mis=%b want 0 0", pend_valid, misalign_err); end
        rst = 0;
        n_checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL boot_cycle0 pc=%h valid=%b want 0 0", pc, pc_valid); end
        tick();
        n_checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin n_errors++; $display("FAIL boot_cycle1 pc=%h valid=%b want 0 1", pc, pc_valid); end
        tick();
        n_checks++; if (pc !== 32'h4) begin n_errors++; $display("FAIL seq_cycle2 pc=%h want 4", pc); end
        tick();
        n_checks++; if (pc !== 32'h8 || pc_plus !== 32'hC) begin n_errors++; $display("FAIL seq_cycle3 pc=%h plus=%h want 8 c", pc, pc_plus); end
    endtask

    task automatic test_stall_pend();
        redirect = 1; redirect_pc = 32'h10; tick();
        n_checks++; if (pc !== 32'h10) begin n_errors++; $display("FAIL redirect_to_10 pc=%h want 10", pc); end
        stall = 1; redirect = 1; redirect_pc = 32'h40; tick();
        n_checks++; if (pc !== 32'h10 || pend_valid !== 1'b1) begin n_errors++; $display("FAIL stall_capture pc=%h pend=%b want 10 1", pc, pend_valid); end
        redirect = 0; tick(); tick();
        n_checks++; if (pc !== 32'h10 || pend_valid !== 1'b1) begin n_errors++; $display("FAIL stall_hold pc=%h pend=%b want 10 1", pc, pend_valid); end
        stall = 0; tick();
        n_checks++; if (pc !== 32'h40 || pend_valid !== 1'b0) begin n_errors++; $display("FAIL pend_apply pc=%h pend=%b want 40 0", pc, pend_valid); end
        tick();
        n_checks++; if (pc !== 32'h44) begin n_errors++; $display("FAIL after_pend pc=%h want 44", pc); end
    endtask

    task automatic test_misalign();
        redirect = 1; redirect_pc = 32'h42; tick();
        n_checks++; if (pc !== 32'h80 || misalign_err !== 1'b1) begin n_errors++; $display("FAIL misalign_vec pc=%h err=%b want 80 1", pc, misalign_err); end
        redirect = 0; tick();
        n_checks++; if (pc !== 32'h84 || misalign_err !== 1'b0) begin n_errors++; $display("FAIL misalign_pulse pc=%h err=%b want 84 0", pc, misalign_err); end
    endtask

    task automatic test_exc_priority();
        redirect = 1; redirect_pc = 32'h20; tick();
        stall = 1; redirect_pc = 32'h60; tick();
        n_checks++; if (pc !== 32'h20 || pend_valid !== 1'b1) begin n_errors++; $display("FAIL exc_setup pc=%h pend=%b want 20 1", pc, pend_valid); end
        exc = 1; redirect_pc = 32'h64; tick();
        n_checks++; if (pc !== 32'h80 || pend_valid !== 1'b0) begin n_errors++; $display("FAIL exc_wins pc=%h pend=%b want 80 0", pc, pend_valid); end
        clear_inputs(); tick();
        n_checks++; if (pc !== 32'h84) begin n_errors++; $display("FAIL exc_then_seq pc=%h want 84", pc); end
    endtask

    task automatic test_halt();
        redirect = 1; redirect_pc = 32'h30; tick();
        redirect = 0; halt = 1; tick();
        n_checks++; if (pc !== 32'h30 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL halt_enter pc=%h valid=%b want 30 0", pc, pc_valid); end
        halt = 0; stall = 1; redirect = 1; redirect_pc = 32'h50; tick(); tick();
        n_checks++; if (pc !== 32'h30 || pc_valid !== 1'b0 || pend_valid !== 1'b0) begin n_errors++; $display("FAIL halt_ignore pc=%h valid=%b pend=%b want 30 0 0", pc, pc_valid, pend_valid); end
        stall = 0; redirect_pc = 32'h52; tick();
        n_checks++; if (pc !== 32'h30 || misalign_err !== 1'b0) begin n_errors++; $display("FAIL halt_misalign pc=%h err=%b want 30 0", pc, misalign_err); end
        redirect = 0; exc = 1; tick();
        n_checks++; if (pc !== 32'h80 || pc_valid !== 1'b1) begin n_errors++; $display("FAIL halt_exit pc=%h valid=%b want 80 1", pc, pc_valid); end
        exc = 0; tick();
        n_checks++; if (pc !== 32'h84) begin n_errors++; $display("FAIL halt_resume pc=%h want 84", pc); end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1; redirect = 1; redirect_pc = 32'h40; tick();
        n_checks++; if (pend_valid !== 1'b1) begin n_errors++; $display("FAIL rst_setup pend=%b want 1", pend_valid); end
        redirect = 0; rst = 1; tick();
        n_checks++; if (pc !== 32'h0 || pend_valid !== 1'b0 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid pc=%h pend=%b valid=%b want 0 0 0", pc, pend_valid, pc_valid); end
        rst = 0; stall = 0; tick(); tick();
        n_checks++; if (pc !== 32'h4) begin n_errors++; $display("FAIL rst_no_stale pc=%h want 4", pc); end
    endtask

    task automatic test_wrap8();
        rst8 = 1; tick();
        rst8 = 0; tick();
        redirect8 = 1; redirect_pc8 = 8'hFC; tick();
        n_checks++; if (pc8 !== 8'hFC || pc_plus8 !== 8'h00) begin n_errors++; $display("FAIL wrap8_top pc=%h plus=%h want fc 00", pc8, pc_plus8); end
        redirect8 = 0; tick();
        n_checks++; if (pc8 !== 8'h00 || pc_valid8 !== 1'b1 || misalign_err8 !== 1'b0 || pend_valid8 !== 1'b0) begin
            n_errors++; $display("FAIL wrap8_next pc=%h valid=%b err=%b pend=%b want 00 1 0 0", pc8, pc_valid8, misalign_err8, pend_valid8);
        end
    endtask

    task automatic test_random();
        clear_inputs(); rst = 1; tick(); rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            exc      = ($urandom_range(0, 19) == 0);
            halt     = ($urandom_range(0, 24) == 0);
            stall    = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 3) == 0);
            redirect_pc = 32'($urandom_range(0, 255)) * 32'd4;
            if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
            tick();
            n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rand_pc cyc=%0d got=%h want=%h", i, pc, m_pc); end
            n_checks++; if (pc_plus !== m_pc + 32'd4) begin n_errors++; $display("FAIL rand_pc_plus cyc=%0d got=%h want=%h", i, pc_plus, m_pc + 32'd4); end
            n_checks++; if (pc_valid !== (m_st == M_RUN)) begin n_errors++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", i, pc_valid, m_st == M_RUN); end
            n_checks++; if (pend_valid !== m_pv) begin n_errors++; $display("FAIL rand_pend cyc=%0d got=%b want=%b", i, pend_valid, m_pv); end
            n_checks++; if (misalign_err !== m_mis) begin n_errors++; $display("FAIL rand_misalign cyc=%0d got=%b want=%b", i, misalign_err, m_mis); end
        end
        clear_inputs();
    endtask

    initial begin
        m_st = M_BOOT; m_pc = 32'h0; m_pv = 1'b0; m_ppc = 32'h0; m_mis = 1'b0;
        rst8 = 1; stall8 = 0; redirect8 = 0; exc8 = 0; halt8 = 0; redirect_pc8 = 8'h0;
        rst = 1; clear_inputs();
        test_reset();
        test_stall_pend();
        test_misalign();
        test_exc_priority();
        test_halt();
        test_reset_mid_stall();
        test_wrap8();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
